// File: rtl/mode_s_reply_sequencer.sv
// Mode S interrogation-to-reply sequencer: qualifies the interrogation, assembles the
// uplink word, then emits the PPM reply at a fixed delay after P6 sync reversal.
module mode_s_reply_sequencer #(
    parameter int CLK_PER_US     = 8,
    parameter int REPLY_DELAY_US = 128,
    parameter int TXN_TIMEOUT_US = 4,
    parameter int SYNC_WINDOW_US = 4,
    parameter int DEAD_US        = 50
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pulse_received,
    input  logic         transaction_valid,
    input  logic         p6_sync_phase_rev,
    input  logic         bit_valid,
    input  logic         bit_value,
    input  logic         reply_ready,
    input  logic [111:0] reply_payload,
    input  logic         reply_long,
    output logic         reply,
    output logic         transfer_data,
    output logic [111:0] uplink_data,
    output logic         uplink_long,
    output logic         rx_error,
    output logic         reply_miss,
    output logic         busy,
    output logic         suppress
);

    localparam int H         = CLK_PER_US / 2;
    localparam int TXN_CYC   = TXN_TIMEOUT_US * CLK_PER_US;
    localparam int SYNC_CYC  = SYNC_WINDOW_US * CLK_PER_US;
    localparam int GAP_CYC   = 2 * CLK_PER_US;
    localparam int DEAD_CYC  = DEAD_US * CLK_PER_US;
    localparam int DELAY_CYC = REPLY_DELAY_US * CLK_PER_US;

    localparam int MAX_A   = (TXN_CYC > SYNC_CYC) ? TXN_CYC : SYNC_CYC;
    localparam int MAX_B   = (GAP_CYC > DEAD_CYC) ? GAP_CYC : DEAD_CYC;
    localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DLY_W   = $clog2(DELAY_CYC + 1);
    localparam int TX_W    = $clog2(120 * CLK_PER_US + 1);
    localparam int SLOT_W  = $clog2(2 * H);

    localparam logic [TMR_W-1:0]  TXN_LAST  = TMR_W'(TXN_CYC - 1);
    localparam logic [TMR_W-1:0]  SYNC_LAST = TMR_W'(SYNC_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0]  DEAD_LAST = TMR_W'(DEAD_CYC - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(DELAY_CYC - 1);
    localparam logic [DLY_W-1:0]  DLY_TOP   = DLY_W'(DELAY_CYC);
    localparam logic [TX_W-1:0]   LEN_SHORT = TX_W'(64 * CLK_PER_US);
    localparam logic [TX_W-1:0]   LEN_LONG  = TX_W'(120 * CLK_PER_US);
    localparam logic [TX_W-1:0]   PRE_LEN   = TX_W'(16 * H);
    localparam logic [SLOT_W-1:0] SLOT_H    = SLOT_W'(H);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * H - 1);

    typedef enum logic [2:0] {
        IDLE, TXN_CHECK, SYNC_WAIT, DATA_RX, REPLY_WAIT, REPLY_TX, DEAD
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [DLY_W-1:0]   dly;
    logic [DLY_W-1:0]   dly_inc;
    logic [6:0]         bit_cnt;
    logic [111:0]       rx_word;
    logic [111:0]       rx_next;
    logic               rx_long;
    logic               first_len;
    logic               last_bit;
    logic [TX_W-1:0]    tx_cnt;
    logic [TX_W-1:0]    tx_len;
    logic [SLOT_W-1:0]  slot;
    logic [111:0]       sr;
    logic               in_pre;
    logic               pre_chip;
    logic               data_chip;

    assign busy     = (state != IDLE);
    assign suppress = (state == DEAD);

    // tx_cnt and slot always describe the chip time being registered on the next edge.
    always_comb begin
        rx_next = rx_word;
        rx_next[7'd111 - bit_cnt] = bit_value;
        first_len = (bit_cnt == 7'd0) ? bit_value : rx_long;
        last_bit  = (bit_cnt == (first_len ? 7'd111 : 7'd55));
        dly_inc   = (dly == DLY_TOP) ? dly : dly + DLY_W'(1);
        in_pre    = (tx_cnt < PRE_LEN);
        pre_chip  = (tx_cnt < TX_W'(H))
                 || ((tx_cnt >= TX_W'(2 * H)) && (tx_cnt < TX_W'(3 * H)))
                 || ((tx_cnt >= TX_W'(7 * H)) && (tx_cnt < TX_W'(8 * H)))
                 || ((tx_cnt >= TX_W'(9 * H)) && (tx_cnt < TX_W'(10 * H)));
        data_chip = sr[111] ? (slot < SLOT_H) : (slot >= SLOT_H);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            tmr           <= '0;
            dly           <= '0;
            bit_cnt       <= '0;
            rx_word       <= '0;
            rx_long       <= 1'b0;
            tx_cnt        <= '0;
            tx_len        <= '0;
            slot          <= '0;
            sr            <= '0;
            reply         <= 1'b0;
            transfer_data <= 1'b0;
            uplink_data   <= '0;
            uplink_long   <= 1'b0;
            rx_error      <= 1'b0;
            reply_miss    <= 1'b0;
        end else begin
            transfer_data <= 1'b0;
            rx_error      <= 1'b0;
            reply_miss    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pulse_received) begin
                        state <= TXN_CHECK;
                        tmr   <= '0;
                    end
                end
                TXN_CHECK: begin
                    if (transaction_valid) begin
                        state <= SYNC_WAIT;
                        tmr   <= '0;
                    end else if (tmr == TXN_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                SYNC_WAIT: begin
                    if (p6_sync_phase_rev) begin
                        state   <= DATA_RX;
                        tmr     <= '0;
                        dly     <= '0;
                        bit_cnt <= '0;
                        rx_word <= '0;
                    end else if (tmr == SYNC_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                DATA_RX: begin
                    dly <= dly_inc;
                    if (bit_valid) begin
                        tmr     <= '0;
                        rx_word <= rx_next;
                        bit_cnt <= bit_cnt + 7'd1;
                        if (bit_cnt == 7'd0) begin
                            rx_long <= bit_value;
                        end
                        if (last_bit) begin
                            uplink_data   <= rx_next;
                            uplink_long   <= first_len;
                            transfer_data <= 1'b1;
                            state         <= REPLY_WAIT;
                        end
                    end else if (tmr == GAP_LAST) begin
                        rx_error <= 1'b1;
                        state    <= DEAD;
                        tmr      <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                REPLY_WAIT: begin
                    // The first preamble chip is registered on the same edge that enters REPLY_TX.
                    if (dly >= DLY_LAST) begin
                        if (reply_ready) begin
                            sr     <= reply_payload;
                            tx_len <= reply_long ? LEN_LONG : LEN_SHORT;
                            tx_cnt <= TX_W'(1);
                            slot   <= '0;
                            reply  <= 1'b1;
                            state  <= REPLY_TX;
                        end else begin
                            reply_miss <= 1'b1;
                            state      <= DEAD;
                            tmr        <= '0;
                        end
                    end else begin
                        dly <= dly_inc;
                    end
                end
                REPLY_TX: begin
                    if (tx_cnt == tx_len) begin
                        reply <= 1'b0;
                        state <= DEAD;
                        tmr   <= '0;
                    end else begin
                        reply  <= in_pre ? pre_chip : data_chip;
                        tx_cnt <= tx_cnt + TX_W'(1);
                        if (!in_pre) begin
                            if (slot == SLOT_LAST) begin
                                slot <= '0;
                                sr   <= {sr[110:0], 1'b0};
                            end else begin
                                slot <= slot + SLOT_W'(1);
                            end
                        end
                    end
                end
                DEAD: begin
                    if (tmr == DEAD_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_s_reply_sequencer.sv
// Self-checking bench for mode_s_reply_sequencer: randomized uplink words and reply
// payloads checked against an arithmetic model of the PPM reply waveform.
module tb_mode_s_reply_sequencer;

    localparam int CPU      = 8;
    localparam int H        = CPU / 2;
    localparam int D        = 128 * CPU;
    localparam int DEAD_CYC = 50 * CPU;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         pulse_received = 1'b0;
    logic         transaction_valid = 1'b0;
    logic         p6_sync_phase_rev = 1'b0;
    logic         bit_valid = 1'b0;
    logic         bit_value = 1'b0;
    logic         reply_ready = 1'b0;
    logic [111:0] reply_payload = '0;
    logic         reply_long = 1'b0;
    logic         reply;
    logic         transfer_data;
    logic [111:0] uplink_data;
    logic         uplink_long;
    logic         rx_error;
    logic         reply_miss;
    logic         busy;
    logic         suppress;

    int total = 0;
    int bad = 0;
    int k = 0;
    int td_seen = 0;
    int err_seen = 0;
    int miss_seen = 0;
    logic [111:0] exp_word;

    mode_s_reply_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .pulse_received(pulse_received), .transaction_valid(transaction_valid),
        .p6_sync_phase_rev(p6_sync_phase_rev), .bit_valid(bit_valid), .bit_value(bit_value),
        .reply_ready(reply_ready), .reply_payload(reply_payload), .reply_long(reply_long),
        .reply(reply), .transfer_data(transfer_data), .uplink_data(uplink_data),
        .uplink_long(uplink_long), .rx_error(rx_error), .reply_miss(reply_miss),
        .busy(busy), .suppress(suppress)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; pulse strobes are tallied here so no other process races them.
    task automatic tick();
        @(negedge clk);
        k++;
        if (transfer_data === 1'b1) td_seen++;
        if (rx_error === 1'b1) err_seen++;
        if (reply_miss === 1'b1) miss_seen++;
    endtask

    function automatic logic [111:0] rand112();
        logic [111:0] p = '0;
        for (int i = 0; i < 4; i++) p = {p[79:0], 32'($urandom())};
        return p;
    endfunction

    function automatic logic model_chip(input int t, input logic [111:0] p, input bit lng);
        int n = lng ? 112 : 56;
        int d;
        int s;
        if (t < 16 * H) begin
            s = t / H;
            return (s == 0) || (s == 2) || (s == 7) || (s == 9);
        end
        d = t - 16 * H;
        if (d / (2 * H) >= n) return 1'b0;
        return p[111 - d / (2 * H)] ? ((d % (2 * H)) < H) : ((d % (2 * H)) >= H);
    endfunction

    task automatic start_to_sync();
        tick(); pulse_received = 1'b1;
        tick(); pulse_received = 1'b0;
        tick(); transaction_valid = 1'b1;
        tick(); transaction_valid = 1'b0;
        tick(); tick(); p6_sync_phase_rev = 1'b1;
        tick(); p6_sync_phase_rev = 1'b0;
        k = 0;
    endtask

    task automatic send_bits(input int n, input bit first);
        bit b;
        exp_word = '0;
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? first : 1'($urandom_range(0, 1));
            bit_value = b;
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
            bit_value = 1'b0;
            exp_word = (exp_word << 1) | 112'(b);
            for (int j = 0; j < CPU - 1; j++) tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check_output({tag, "_idle"}, 112'(busy), 112'(0));
    endtask

    task automatic expect_reply(input string tag, input logic [111:0] p, input bit lng, input bit poke);
        int len = (lng ? 120 : 64) * CPU;
        int early = 0;
        int wrong = 0;
        int sup = 0;
        while (k < D - 1) begin
            tick();
            if (reply !== 1'b0) early++;
        end
        check_output({tag, "_early"}, 112'(early), 112'(0));
        for (int t = 0; t <= len; t++) begin
            tick();
            if (t == 0) check_output({tag, "_first_chip"}, 112'(reply), 112'(1));
            if (reply !== model_chip(t, p, lng)) wrong++;
        end
        check_output({tag, "_wave"}, 112'(wrong), 112'(0));
        while (suppress === 1'b1 && sup < DEAD_CYC + 20) begin
            sup++;
            pulse_received = poke && (sup == 5);
            tick();
        end
        pulse_received = 1'b0;
        check_output({tag, "_dead_len"}, 112'(sup), 112'(DEAD_CYC));
        check_output({tag, "_busy_after"}, 112'(busy), 112'(0));
    endtask

    task automatic full_path(input string tag, input bit up_long, input bit rp_long, input bit poke);
        logic [111:0] p = rand112();
        int td0 = td_seen;
        int n = up_long ? 112 : 56;
        if (!up_long) p[111:104] = 8'hA5;
        reply_payload = p;
        reply_long = rp_long;
        reply_ready = 1'b1;
        start_to_sync();
        send_bits(n, up_long);
        check_output({tag, "_td"}, 112'(td_seen - td0), 112'(1));
        check_output({tag, "_uplink"}, uplink_data, exp_word << (112 - n));
        check_output({tag, "_uplink_long"}, 112'(uplink_long), 112'(up_long));
        expect_reply(tag, p, rp_long, poke);
    endtask

    initial begin
        int e0;
        int m0;
        int td0;
        int hi;

        repeat (3) tick();
        check_output("rst_reply", 112'(reply), 112'(0));
        check_output("rst_busy", 112'(busy), 112'(0));
        check_output("rst_suppress", 112'(suppress), 112'(0));
        check_output("rst_td", 112'(transfer_data), 112'(0));
        check_output("rst_uplink", uplink_data, 112'(0));
        check_output("rst_uplink_long", 112'(uplink_long), 112'(0));
        check_output("rst_rx_error", 112'(rx_error), 112'(0));
        check_output("rst_reply_miss", 112'(reply_miss), 112'(0));
        reset_n = 1'b1;
        tick();

        full_path("short", 1'b0, 1'b0, 1'b0);
        full_path("long", 1'b1, 1'b1, 1'b0);
        full_path("mixed", 1'b1, 1'b0, 1'b0);

        $display("[TB] transaction timeout");
        e0 = err_seen; m0 = miss_seen; td0 = td_seen;
        tick(); pulse_received = 1'b1;
        tick(); pulse_received = 1'b0;
        repeat (20) tick();
        check_output("txn_to_busy", 112'(busy), 112'(1));
        repeat (20) tick();
        check_output("txn_to_idle", 112'(busy), 112'(0));
        check_output("txn_to_strobes", 112'((err_seen - e0) + (miss_seen - m0) + (td_seen - td0)), 112'(0));
        check_output("txn_to_suppress", 112'(suppress), 112'(0));

        $display("[TB] sync timeout");
        tick(); pulse_received = 1'b1;
        tick(); pulse_received = 1'b0;
        tick(); transaction_valid = 1'b1;
        tick(); transaction_valid = 1'b0;
        repeat (20) tick();
        check_output("sync_to_busy", 112'(busy), 112'(1));
        repeat (20) tick();
        check_output("sync_to_idle", 112'(busy), 112'(0));
        check_output("sync_to_suppress", 112'(suppress), 112'(0));

        $display("[TB] bit gap");
        e0 = err_seen; td0 = td_seen;
        start_to_sync();
        send_bits(10, 1'b1);
        check_output("gap_no_early_err", 112'(err_seen - e0), 112'(0));
        repeat (2 * CPU + 4) tick();
        check_output("gap_rx_error", 112'(err_seen - e0), 112'(1));
        check_output("gap_no_td", 112'(td_seen - td0), 112'(0));
        check_output("gap_suppress", 112'(suppress), 112'(1));
        wait_idle("gap");

        $display("[TB] reply not ready");
        m0 = miss_seen; hi = 0;
        reply_ready = 1'b0;
        reply_payload = rand112();
        start_to_sync();
        send_bits(56, 1'b0);
        while (k < D + 4) begin
            tick();
            if (reply !== 1'b0) hi++;
        end
        check_output("miss_pulse", 112'(miss_seen - m0), 112'(1));
        check_output("miss_reply_low", 112'(hi), 112'(0));
        check_output("miss_suppress", 112'(suppress), 112'(1));
        wait_idle("miss");

        $display("[TB] reset mid-reply");
        reply_ready = 1'b1;
        reply_long = 1'b0;
        reply_payload = rand112();
        start_to_sync();
        send_bits(56, 1'b0);
        while (k < D + 2 * H) tick();
        check_output("rst_mid_high", 112'(reply), 112'(1));
        #1 reset_n = 1'b0;
        #1;
        check_output("rst_mid_async", 112'(reply), 112'(0));
        check_output("rst_mid_busy", 112'(busy), 112'(0));
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check_output("rst_mid_uplink", uplink_data, 112'(0));

        full_path("after_rst", 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
